window_3x3: RTL and testbench

WINDOW_3X3 -- requirements
Module: window_3x3

---
 rtl/window_3x3_if.sv | 22 ++
 rtl/window_3x3.sv | 102 ++++++++++
 tb/tb_window_3x3.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_3x3_if.sv
// Pixel-stream input and 3x3-window output bus of window_3x3.
// The slave side is the window generator.
interface window_3x3_if #(
  parameter int N       = 8,
  parameter int CHANNEL = 3
);
  logic                   input_vld;
  logic [CHANNEL*N-1:0]   input_din;
  logic [9*CHANNEL*N-1:0] window_dout;
  logic                   window_dout_vld;
  logic                   window_dout_end;

  modport master (
    output input_vld, input_din,
    input  window_dout, window_dout_vld, window_dout_end
  );

  modport slave (
    input  input_vld, input_din,
    output window_dout, window_dout_vld, window_dout_end
  );
endinterface

// File: rtl/window_3x3.sv
// Sliding 3x3 window generator over a raster-order SIZE x SIZE frame.
// Two line buffers supply the pixels one and two rows above the incoming pixel.
module window_3x3 #(
  parameter int N       = 8,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  window_3x3_if.slave bus
);
  localparam int PW = CHANNEL * N;
  localparam int CW = $clog2(SIZE);

  typedef logic [PW-1:0] pixel_t;

  logic [CW-1:0]     row;
  logic [CW-1:0]     col;
  pixel_t            line1 [SIZE];
  pixel_t            line2 [SIZE];
  pixel_t            win      [3][3];
  pixel_t            win_next [3][3];
  logic [9*PW-1:0]   win_flat;
  logic [9*PW-1:0]   dout_q;
  logic              vld_q;
  logic              end_q;
  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              win_ready;

  assign accept    = ce & bus.input_vld;
  assign last_col  = (col == CW'(SIZE - 1));
  assign last_row  = (row == CW'(SIZE - 1));
  // A window is complete only once three rows and three columns of this frame are in.
  assign win_ready = (row >= CW'(2)) && (col >= CW'(2));

  // Window after the next shift: drop column 0, append {line2, line1, input} on the right.
  // NOTE: every always_comb output is assigned on every path; a missed branch would infer a latch.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      win_next[r][0] = win[r][1];
      win_next[r][1] = win[r][2];
    end
    win_next[0][2] = line2[col];
    win_next[1][2] = line1[col];
    win_next[2][2] = bus.input_din;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat[(r*3+c)*PW +: PW] = win_next[r][c];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (!ce) begin
      row <= '0;
      col <= '0;
    end else if (bus.input_vld) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // NOTE: line buffers and window registers carry no reset so they map onto plain storage;
  // every window output is built only from pixels written earlier in the same frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      line1[col] <= bus.input_din;
      line2[col] <= line1[col];
      win        <= win_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      end_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q <= accept & win_ready;
      end_q <= accept & win_ready & last_col & last_row;
      if (accept && win_ready) begin
        dout_q <= win_flat;
      end
    end
  end

  assign bus.window_dout     = dout_q;
  assign bus.window_dout_vld = vld_q;
  assign bus.window_dout_end = end_q;
endmodule

// File: tb/tb_window_3x3.sv
// Self-checking bench for window_3x3: directed 4x4 mono frames plus a random 34x34 RGB frame,
// each compared against a frame-array reference model.
module tb_window_3x3;
  localparam int SS  = 4;
  localparam int SC  = 1;
  localparam int SN  = 8;
  localparam int SPW = SC * SN;
  localparam int BS  = 34;
  localparam int BC  = 3;
  localparam int BN  = 8;
  localparam int BPW = BC * BN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic s_ce  = 1'b0;
  logic b_ce  = 1'b0;

  always #5 clk = ~clk;

  window_3x3_if #(.N(SN), .CHANNEL(SC)) s_bus ();
  window_3x3_if #(.N(BN), .CHANNEL(BC)) b_bus ();

  window_3x3 #(.N(SN), .CHANNEL(SC), .SIZE(SS)) u_small (
    .clk(clk), .rst_n(rst_n), .ce(s_ce), .bus(s_bus)
  );
  window_3x3 #(.N(BN), .CHANNEL(BC), .SIZE(BS)) u_big (
    .clk(clk), .rst_n(rst_n), .ce(b_ce), .bus(b_bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: pixels of the current frame indexed by raster position.
  logic [SPW-1:0]   s_frame [SS*SS];
  int               s_k = 0;
  logic [9*SPW-1:0] s_exp_win = '0;
  logic             s_exp_vld, s_exp_end;
  int               s_wins, s_ends;
  logic [9*SPW-1:0] s_first, s_last_obs;

  logic [BPW-1:0]   b_frame [BS*BS];
  int               b_k = 0;
  logic [9*BPW-1:0] b_exp_win = '0;
  logic             b_exp_vld, b_exp_end;
  int               b_wins, b_ends, b_end_idx;

  task automatic check(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    int v [9];
    logic [71:0] w;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = v[i][7:0];
    return w;
  endfunction

  task automatic s_step(input bit ce_v, input bit vld, input logic [SPW-1:0] d);
    int r, c;
    @(negedge clk);
    s_ce = ce_v;
    s_bus.input_vld = vld;
    s_bus.input_din = d;
    s_exp_vld = 1'b0;
    s_exp_end = 1'b0;
    if (!ce_v) s_k = 0;
    else if (vld) begin
      s_frame[s_k] = d;
      r = s_k / SS;
      c = s_k % SS;
      if (r >= 2 && c >= 2) begin
        s_exp_vld = 1'b1;
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            s_exp_win[(wr*3+wc)*SPW +: SPW] = s_frame[(r-2+wr)*SS + (c-2+wc)];
      end
      s_exp_end = (s_k == SS*SS - 1);
      s_k = (s_k + 1) % (SS*SS);
    end
    @(posedge clk);
    #1;
    check("s_vld", 216'(s_bus.window_dout_vld), 216'(s_exp_vld));
    check("s_end", 216'(s_bus.window_dout_end), 216'(s_exp_end));
    check("s_dout", 216'(s_bus.window_dout), 216'(s_exp_win));
    if (s_bus.window_dout_vld === 1'b1) begin
      if (s_wins == 0) s_first = s_bus.window_dout;
      s_last_obs = s_bus.window_dout;
      s_wins++;
    end
    if (s_bus.window_dout_end === 1'b1) s_ends++;
  endtask

  task automatic b_step(input bit vld, input logic [BPW-1:0] d);
    int r, c;
    @(negedge clk);
    b_ce = 1'b1;
    b_bus.input_vld = vld;
    b_bus.input_din = d;
    b_exp_vld = 1'b0;
    b_exp_end = 1'b0;
    if (vld) begin
      b_frame[b_k] = d;
      r = b_k / BS;
      c = b_k % BS;
      if (r >= 2 && c >= 2) begin
        b_exp_vld = 1'b1;
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            b_exp_win[(wr*3+wc)*BPW +: BPW] = b_frame[(r-2+wr)*BS + (c-2+wc)];
      end
      b_exp_end = (b_k == BS*BS - 1);
      b_k = (b_k + 1) % (BS*BS);
    end
    @(posedge clk);
    #1;
    check("b_vld", 216'(b_bus.window_dout_vld), 216'(b_exp_vld));
    check("b_end", 216'(b_bus.window_dout_end), 216'(b_exp_end));
    check("b_dout", 216'(b_bus.window_dout), 216'(b_exp_win));
    if (b_bus.window_dout_vld === 1'b1) b_wins++;
    if (b_bus.window_dout_end === 1'b1) begin
      b_ends++;
      b_end_idx = b_wins;
    end
  endtask

  initial begin
    int accepted;
    bit v;
    s_bus.input_vld = 1'b0;
    s_bus.input_din = '0;
    b_bus.input_vld = 1'b0;
    b_bus.input_din = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_vld", 216'(s_bus.window_dout_vld), 216'(0));
    check("rst_s_end", 216'(s_bus.window_dout_end), 216'(0));
    check("rst_s_dout", 216'(s_bus.window_dout), 216'(0));
    check("rst_b_dout", 216'(b_bus.window_dout), 216'(0));
    rst_n = 1'b1;

    // Back-to-back frame 0..15
    s_wins = 0; s_ends = 0;
    for (int i = 0; i < 16; i++) s_step(1'b1, 1'b1, SPW'(i));
    repeat (2) s_step(1'b1, 1'b0, '0);
    check("t1_count", 216'(s_wins), 216'(4));
    check("t1_ends", 216'(s_ends), 216'(1));
    check("t1_first", 216'(s_first), 216'(pack9(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    check("t1_last", 216'(s_last_obs), 216'(pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)));

    // Same frame with gaps 1,0,0
    s_wins = 0; s_ends = 0;
    for (int i = 0; i < 16; i++) begin
      s_step(1'b1, 1'b1, SPW'(i));
      s_step(1'b1, 1'b0, SPW'($urandom));
      s_step(1'b1, 1'b0, SPW'($urandom));
    end
    check("t2_count", 216'(s_wins), 216'(4));
    check("t2_first", 216'(s_first), 216'(pack9(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    check("t2_last", 216'(s_last_obs), 216'(pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)));

    // Two frames back-to-back
    s_wins = 0; s_ends = 0;
    for (int i = 0; i < 16; i++) s_step(1'b1, 1'b1, SPW'(i));
    check("t3_count_f1", 216'(s_wins), 216'(4));
    s_wins = 0;
    for (int i = 0; i < 16; i++) s_step(1'b1, 1'b1, SPW'(100 + i));
    s_step(1'b1, 1'b0, '0);
    check("t3_count_f2", 216'(s_wins), 216'(4));
    check("t3_ends", 216'(s_ends), 216'(2));
    check("t3_first_f2", 216'(s_first), 216'(pack9(100, 101, 102, 104, 105, 106, 108, 109, 110)));

    // Reset mid-frame after pixel 9, asynchronous to the clock
    for (int i = 0; i < 10; i++) s_step(1'b1, 1'b1, SPW'(i));
    s_step(1'b1, 1'b0, '0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t4_async_vld", 216'(s_bus.window_dout_vld), 216'(0));
    check("t4_async_dout", 216'(s_bus.window_dout), 216'(0));
    s_k = 0; s_exp_win = '0;
    b_k = 0; b_exp_win = '0;
    @(negedge clk);
    rst_n = 1'b1;
    s_wins = 0; s_ends = 0;
    for (int i = 0; i < 16; i++) s_step(1'b1, 1'b1, SPW'(i));
    s_step(1'b1, 1'b0, '0);
    check("t4_count", 216'(s_wins), 216'(4));
    check("t4_first", 216'(s_first), 216'(pack9(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    check("t4_last", 216'(s_last_obs), 216'(pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)));

    // ce low for 3 cycles after pixel 12, then a fresh frame 50..65
    for (int i = 0; i < 13; i++) s_step(1'b1, 1'b1, SPW'(i));
    s_wins = 0; s_ends = 0;
    for (int i = 0; i < 3; i++) s_step(1'b0, 1'b1, SPW'($urandom));
    check("t5_quiet", 216'(s_wins), 216'(0));
    for (int i = 0; i < 16; i++) s_step(1'b1, 1'b1, SPW'(50 + i));
    s_step(1'b1, 1'b0, '0);
    check("t5_count", 216'(s_wins), 216'(4));
    check("t5_first", 216'(s_first), 216'(pack9(50, 51, 52, 54, 55, 56, 58, 59, 60)));
    check("t5_last", 216'(s_last_obs), 216'(pack9(55, 56, 57, 59, 60, 61, 63, 64, 65)));

    // Random 34x34 RGB frame with random gaps
    b_wins = 0; b_ends = 0; b_end_idx = 0;
    accepted = 0;
    while (accepted < BS*BS) begin
      v = ($urandom_range(0, 3) != 0);
      b_step(v, BPW'($urandom));
      if (v) accepted++;
    end
    repeat (2) b_step(1'b0, '0);
    check("t6_count", 216'(b_wins), 216'(1024));
    check("t6_ends", 216'(b_ends), 216'(1));
    check("t6_end_idx", 216'(b_end_idx), 216'(1024));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
